// File: rtl/sim_sram_pkg.sv
// Shared types for the burst arbiter in front of the simulation SRAM word port.
package sim_sram_pkg;

    localparam int unsigned N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } sram_arb_state_e;

    typedef logic owner_t;

    // One-hot per-requester vector for a given owner.
    function automatic logic [N_REQ-1:0] owner_onehot(input owner_t o);
        return {o, ~o};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; the last_grant register lives in the parent.
module rr_arb2
    import sim_sram_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid,
    input  owner_t           last_grant,
    output logic [N_REQ-1:0] grant_c,
    output owner_t           winner_c,
    output logic             any_c
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        winner_c = 1'b0;
        if (req_valid == 2'b11) begin
            winner_c = ~last_grant;
        end else if (req_valid[1]) begin
            winner_c = 1'b1;
        end
    end

    assign any_c   = |req_valid;
    assign grant_c = any_c ? owner_onehot(winner_c) : '0;

endmodule

// File: rtl/sim_sram_burst_arb.sv
// Burst controller with 2-way round-robin arbitration over one single-port sim SRAM.
// One burst at a time; one beat per cycle; read data returned to the burst owner.
module sim_sram_burst_arb
    import sim_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        beat_ack,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        rdata_valid,
    output logic [N_REQ-1:0]        done,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    sram_arb_state_e   state, state_nxt;
    owner_t            owner, last_grant, win_c, src_c;
    logic [N_REQ-1:0]  win_grant_c;
    logic              win_any_c;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q, cnt, cnt_inc_c;
    logic              accept_c, last_beat_c;

    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [LEN_W-1:0]  sel_len_c;
    logic [DATA_W-1:0] sel_wdata_c;

    logic              mem_en_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [N_REQ-1:0]  beat_ack_d, rdata_valid_d, done_d;

    rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant_c    (win_grant_c),
        .winner_c   (win_c),
        .any_c      (win_any_c)
    );

    assign accept_c    = (state == IDLE) && win_any_c;
    assign last_beat_c = (state == BURST) && (cnt == len_q);
    assign cnt_inc_c   = cnt + LEN_W'(1);
    // wdata comes from the arbiter winner while idle, from the latched owner during a burst.
    assign src_c       = (state == IDLE) ? win_c : owner;

    assign sel_we_c    = req_we[win_c];
    assign sel_addr_c  = win_c ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign sel_len_c   = win_c ? req_len[2*LEN_W-1:LEN_W]    : req_len[LEN_W-1:0];
    assign sel_wdata_c = src_c ? wdata[2*DATA_W-1:DATA_W]    : wdata[DATA_W-1:0];

    // Read data passes straight through from the SRAM so it lines up with rdata_valid.
    assign rdata = (|rdata_valid) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = BURST;
            BURST:   if (last_beat_c) state_nxt = we_q ? IDLE : DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs: each beat is prepared one cycle ahead.
    always_comb begin
        req_ready     = '0;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        beat_ack_d    = '0;
        done_d        = '0;
        rdata_valid_d = (mem_en && !mem_we) ? owner_onehot(owner) : '0;
        case (state)
            IDLE: begin
                req_ready = win_grant_c;
                if (accept_c) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we_c;
                    mem_addr_d  = sel_addr_c;
                    mem_wdata_d = sel_we_c ? sel_wdata_c : '0;
                    beat_ack_d  = win_grant_c;
                end
            end
            BURST: begin
                if (last_beat_c) begin
                    done_d = owner_onehot(owner);
                end else begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = addr_q + ADDR_W'(cnt_inc_c);
                    mem_wdata_d = we_q ? sel_wdata_c : '0;
                    beat_ack_d  = owner_onehot(owner);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            beat_ack    <= '0;
            rdata_valid <= '0;
            done        <= '0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt         <= '0;
        end else begin
            mem_en      <= mem_en_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            beat_ack    <= beat_ack_d;
            rdata_valid <= rdata_valid_d;
            done        <= done_d;
            if (accept_c) begin
                owner      <= win_c;
                last_grant <= win_c;
                we_q       <= sel_we_c;
                addr_q     <= sel_addr_c;
                len_q      <= sel_len_c;
                cnt        <= '0;
            end else if ((state == BURST) && !last_beat_c) begin
                cnt <= cnt_inc_c;
            end
        end
    end

endmodule
